// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives a 1-cycle-latency synchronous imem,
// absorbs decode stalls with a 1-entry skid buffer and applies EX redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        valid_id,
    output logic [31:0] pc_id,
    output logic [31:0] ir_id,
    output logic        fault_id
);

    logic [31:0] pc_q, pc_d;
    logic        pc_fault_q, pc_fault_d;
    logic        fault_pend_q, fault_pend_d;
    logic        inflight_v_q, inflight_v_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        skid_v_q, skid_v_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_ir_q, skid_ir_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] ir_id_q, ir_id_d;
    logic        fault_id_q, fault_id_d;

    assign imem_req  = !rst && !stall && !redirect && !pc_fault_q;
    assign imem_addr = pc_q;
    assign valid_id  = valid_q;
    assign pc_id     = pc_id_q;
    assign ir_id     = ir_id_q;
    assign fault_id  = fault_id_q;

    always_comb begin
        pc_d          = pc_q;
        pc_fault_d    = pc_fault_q;
        fault_pend_d  = fault_pend_q;
        inflight_v_d  = imem_req;
        inflight_pc_d = pc_q;
        skid_v_d      = skid_v_q;
        skid_pc_d     = skid_pc_q;
        skid_ir_d     = skid_ir_q;
        valid_d       = valid_q;
        pc_id_d       = pc_id_q;
        ir_id_d       = ir_id_q;
        fault_id_d    = fault_id_q;

        if (imem_req) begin
            pc_d = pc_q + 32'd4;
        end

        if (redirect) begin
            // Kill everything younger than the branch, including the in-flight response.
            pc_d         = redirect_pc;
            pc_fault_d   = |redirect_pc[1:0];
            fault_pend_d = |redirect_pc[1:0];
            skid_v_d     = 1'b0;
            valid_d      = 1'b0;
            fault_id_d   = 1'b0;
        end else if (!stall) begin
            fault_id_d = 1'b0;
            if (fault_pend_q) begin
                valid_d      = 1'b1;
                pc_id_d      = pc_q;
                ir_id_d      = NOP_INSN;
                fault_id_d   = 1'b1;
                fault_pend_d = 1'b0;
            end else if (skid_v_q) begin
                valid_d  = 1'b1;
                pc_id_d  = skid_pc_q;
                ir_id_d  = skid_ir_q;
                skid_v_d = 1'b0;
            end else if (inflight_v_q) begin
                valid_d = 1'b1;
                pc_id_d = inflight_pc_q;
                ir_id_d = imem_rdata;
            end else begin
                valid_d = 1'b0;
            end
        end else if (inflight_v_q) begin
            skid_v_d  = 1'b1;
            skid_pc_d = inflight_pc_q;
            skid_ir_d = imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            pc_fault_q    <= 1'b0;
            fault_pend_q  <= 1'b0;
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= '0;
            skid_v_q      <= 1'b0;
            skid_pc_q     <= '0;
            skid_ir_q     <= '0;
            valid_q       <= 1'b0;
            pc_id_q       <= '0;
            ir_id_q       <= '0;
            fault_id_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pc_fault_q    <= pc_fault_d;
            fault_pend_q  <= fault_pend_d;
            inflight_v_q  <= inflight_v_d;
            inflight_pc_q <= inflight_pc_d;
            skid_v_q      <= skid_v_d;
            skid_pc_q     <= skid_pc_d;
            skid_ir_q     <= skid_ir_d;
            valid_q       <= valid_d;
            pc_id_q       <= pc_id_d;
            ir_id_q       <= ir_id_d;
            fault_id_q    <= fault_id_d;
        end
    end

    // A response landing on an already-full skid would silently drop an instruction.
    skid_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(stall && !redirect && inflight_v_q && skid_v_q));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: ROM word i holds value i; a scoreboard queue tracks the decode stream.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        valid_id;
    logic [31:0] pc_id;
    logic [31:0] ir_id;
    logic        fault_id;

    int errors = 0;
    int checks = 0;
    int cur = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        fault;
    } exp_t;
    exp_t exp_q[$];

    logic [65:0] id_bus;
    assign id_bus = {valid_id, pc_id, ir_id, fault_id};

    fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP_INSN(32'h0000_0013)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .valid_id(valid_id),
        .pc_id(pc_id),
        .ir_id(ir_id),
        .fault_id(fault_id)
    );

    always #5 clk = ~clk;

    // Synchronous ROM, 1-cycle latency: word index i returns i.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= {2'b00, imem_addr[31:2]};
    end

    // Decode-side monitor: an instruction is consumed when live, not stalled and not flushed.
    always @(negedge clk) begin
        if (!rst && valid_id && !stall && !redirect) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc_id=%h ir_id=%h fault_id=%b, required no instruction",
                         pc_id, ir_id, fault_id);
            end else begin
                e = exp_q.pop_front();
                if ({pc_id, ir_id, fault_id} !== {e.pc, e.ir, e.fault}) begin
                    errors++;
                    $display("FAIL sb_stream: got pc=%h ir=%h f=%b, required pc=%h ir=%h f=%b",
                             pc_id, ir_id, fault_id, e.pc, e.ir, e.fault);
                end
            end
        end
    end

    function automatic logic [65:0] idv(input logic v, input logic [31:0] pc,
                                        input logic [31:0] ir, input logic f);
        return {v, pc, ir, f};
    endfunction

    task automatic push(input logic [31:0] pc, input logic [31:0] ir, input logic f);
        exp_q.push_back('{pc, ir, f});
    endtask

    task automatic at(input int k);
        while (cur < k) begin
            @(posedge clk);
            #1;
            cur++;
        end
    endtask

    // Leaves the bench in cycle 0: first cycle with rst low, registers freshly reset.
    task automatic apply_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        cur = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (id_bus !== idv(1'b0, 32'd0, 32'd0, 1'b0)) begin
            errors++; $display("FAIL reset_outputs: got %h required %h", id_bus, idv(1'b0, 32'd0, 32'd0, 1'b0));
        end
        checks++;
        if ({imem_req, imem_addr} !== {1'b0, 32'd0}) begin
            errors++; $display("FAIL reset_req: got req=%b addr=%h required req=0 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        push(32'd0, 32'd0, 1'b0); push(32'd4, 32'd1, 1'b0);
        push(32'd8, 32'd2, 1'b0); push(32'd12, 32'd3, 1'b0);
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'd0}) begin
            errors++; $display("FAIL stream_req0: got req=%b addr=%h required req=1 addr=0", imem_req, imem_addr);
        end
        at(1); @(negedge clk);
        checks++;
        if (valid_id !== 1'b0) begin
            errors++; $display("FAIL stream_c1_valid: got %b required 0", valid_id);
        end
        at(2); @(negedge clk);
        checks++;
        if (id_bus !== idv(1'b1, 32'd0, 32'd0, 1'b0)) begin
            errors++; $display("FAIL stream_c2: got %h required %h", id_bus, idv(1'b1, 32'd0, 32'd0, 1'b0));
        end
        at(3); @(negedge clk);
        checks++;
        if (id_bus !== idv(1'b1, 32'd4, 32'd1, 1'b0)) begin
            errors++; $display("FAIL stream_c3: got %h required %h", id_bus, idv(1'b1, 32'd4, 32'd1, 1'b0));
        end
        at(5); @(negedge clk);
        checks++;
        if (id_bus !== idv(1'b1, 32'd12, 32'd3, 1'b0)) begin
            errors++; $display("FAIL stream_c5: got %h required %h", id_bus, idv(1'b1, 32'd12, 32'd3, 1'b0));
        end
        at(6); rst = 1'b1; @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL stream_drain: got %0d left required 0", exp_q.size());
        end
    endtask

    task automatic test_stall();
        apply_reset();
        push(32'd0, 32'd0, 1'b0); push(32'd4, 32'd1, 1'b0); push(32'd8, 32'd2, 1'b0);
        push(32'd12, 32'd3, 1'b0); push(32'd16, 32'd4, 1'b0);
        for (int c = 4; c <= 6; c++) begin
            at(c); stall = 1'b1; @(negedge clk);
            checks++;
            if ({id_bus, imem_req} !== {idv(1'b1, 32'd8, 32'd2, 1'b0), 1'b0}) begin
                errors++; $display("FAIL stall_hold_c%0d: got id=%h req=%b required id=%h req=0",
                                   c, id_bus, imem_req, idv(1'b1, 32'd8, 32'd2, 1'b0));
            end
        end
        at(7); stall = 1'b0; @(negedge clk);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'd16}) begin
            errors++; $display("FAIL stall_release_req: got req=%b addr=%h required req=1 addr=10", imem_req, imem_addr);
        end
        at(8); @(negedge clk);
        checks++;
        if (id_bus !== idv(1'b1, 32'd12, 32'd3, 1'b0)) begin
            errors++; $display("FAIL stall_skid_out: got %h required %h", id_bus, idv(1'b1, 32'd12, 32'd3, 1'b0));
        end
        at(9); @(negedge clk);
        checks++;
        if (id_bus !== idv(1'b1, 32'd16, 32'd4, 1'b0)) begin
            errors++; $display("FAIL stall_next: got %h required %h", id_bus, idv(1'b1, 32'd16, 32'd4, 1'b0));
        end
        at(10); rst = 1'b1; @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL stall_drain: got %0d left required 0", exp_q.size());
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        push(32'd0, 32'd0, 1'b0); push(32'h100, 32'h40, 1'b0); push(32'h104, 32'h41, 1'b0);
        at(3); redirect = 1'b1; redirect_pc = 32'h100; @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL redir_req_low: got %b required 0", imem_req);
        end
        at(4); redirect = 1'b0; @(negedge clk);
        checks++;
        if ({valid_id, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
            errors++; $display("FAIL redir_c4: got valid=%b req=%b addr=%h required valid=0 req=1 addr=100",
                               valid_id, imem_req, imem_addr);
        end
        at(5); @(negedge clk);
        checks++;
        if (valid_id !== 1'b0) begin
            errors++; $display("FAIL redir_c5_valid: got %b required 0", valid_id);
        end
        at(6); @(negedge clk);
        checks++;
        if (id_bus !== idv(1'b1, 32'h100, 32'h40, 1'b0)) begin
            errors++; $display("FAIL redir_target: got %h required %h", id_bus, idv(1'b1, 32'h100, 32'h40, 1'b0));
        end
        at(8); rst = 1'b1; @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL redir_drain: got %0d left required 0", exp_q.size());
        end
    endtask

    task automatic test_redirect_stall();
        apply_reset();
        push(32'd0, 32'd0, 1'b0); push(32'd4, 32'd1, 1'b0);
        push(32'h200, 32'h80, 1'b0); push(32'h204, 32'h81, 1'b0);
        at(4); stall = 1'b1;
        at(5); redirect = 1'b1; redirect_pc = 32'h200; @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL rs_req_low: got %b required 0", imem_req);
        end
        at(6); redirect = 1'b0; @(negedge clk);
        checks++;
        if ({valid_id, imem_req} !== 2'b00) begin
            errors++; $display("FAIL rs_flushed: got valid=%b req=%b required valid=0 req=0", valid_id, imem_req);
        end
        at(7); stall = 1'b0; @(negedge clk);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin
            errors++; $display("FAIL rs_target_req: got req=%b addr=%h required req=1 addr=200", imem_req, imem_addr);
        end
        at(8); @(negedge clk);
        checks++;
        if (valid_id !== 1'b0) begin
            errors++; $display("FAIL rs_skid_cleared: got valid=%b pc_id=%h required valid=0", valid_id, pc_id);
        end
        at(9); @(negedge clk);
        checks++;
        if (id_bus !== idv(1'b1, 32'h200, 32'h80, 1'b0)) begin
            errors++; $display("FAIL rs_target: got %h required %h", id_bus, idv(1'b1, 32'h200, 32'h80, 1'b0));
        end
        at(11); rst = 1'b1; @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rs_drain: got %0d left required 0", exp_q.size());
        end
    endtask

    task automatic test_misaligned();
        apply_reset();
        push(32'd0, 32'd0, 1'b0); push(32'h102, 32'h13, 1'b1); push(32'h20, 32'd8, 1'b0);
        at(3); redirect = 1'b1; redirect_pc = 32'h102;
        at(4); redirect = 1'b0; @(negedge clk);
        checks++;
        if ({valid_id, imem_req, imem_addr} !== {1'b0, 1'b0, 32'h102}) begin
            errors++; $display("FAIL mis_c4: got valid=%b req=%b addr=%h required valid=0 req=0 addr=102",
                               valid_id, imem_req, imem_addr);
        end
        at(5); @(negedge clk);
        checks++;
        if ({id_bus, imem_req} !== {idv(1'b1, 32'h102, 32'h13, 1'b1), 1'b0}) begin
            errors++; $display("FAIL mis_fault: got id=%h req=%b required id=%h req=0",
                               id_bus, imem_req, idv(1'b1, 32'h102, 32'h13, 1'b1));
        end
        for (int c = 6; c <= 8; c++) begin
            at(c); @(negedge clk);
            checks++;
            if ({valid_id, imem_req} !== 2'b00) begin
                errors++; $display("FAIL mis_idle_c%0d: got valid=%b req=%b required 0 0", c, valid_id, imem_req);
            end
        end
        at(9); redirect = 1'b1; redirect_pc = 32'h20;
        at(10); redirect = 1'b0; @(negedge clk);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h20}) begin
            errors++; $display("FAIL mis_recover_req: got req=%b addr=%h required req=1 addr=20", imem_req, imem_addr);
        end
        at(12); @(negedge clk);
        checks++;
        if (id_bus !== idv(1'b1, 32'h20, 32'd8, 1'b0)) begin
            errors++; $display("FAIL mis_recover: got %h required %h", id_bus, idv(1'b1, 32'h20, 32'd8, 1'b0));
        end
        at(13); rst = 1'b1; @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL mis_drain: got %0d left required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        push(32'd0, 32'd0, 1'b0); push(32'd4, 32'd1, 1'b0);
        push(32'd0, 32'd0, 1'b0); push(32'd4, 32'd1, 1'b0);
        at(4); stall = 1'b1;
        at(5); rst = 1'b1;
        at(6); rst = 1'b0; stall = 1'b0; @(negedge clk);
        checks++;
        if ({id_bus, imem_req, imem_addr} !== {idv(1'b0, 32'd0, 32'd0, 1'b0), 1'b1, 32'd0}) begin
            errors++; $display("FAIL midrst_zero: got id=%h req=%b addr=%h required id=0 req=1 addr=0",
                               id_bus, imem_req, imem_addr);
        end
        at(7); @(negedge clk);
        checks++;
        if (valid_id !== 1'b0) begin
            errors++; $display("FAIL midrst_no_stale: got valid=%b pc_id=%h required valid=0", valid_id, pc_id);
        end
        at(8); @(negedge clk);
        checks++;
        if (id_bus !== idv(1'b1, 32'd0, 32'd0, 1'b0)) begin
            errors++; $display("FAIL midrst_restart: got %h required %h", id_bus, idv(1'b1, 32'd0, 32'd0, 1'b0));
        end
        at(10); rst = 1'b1; @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL midrst_drain: got %0d left required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_misaligned();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

endmodule
